mem_port_master: RTL and testbench

- Initiator side of the Memoria data port (Op2En/Op2RW/ReadWriteAddr/Data).
- Accepts load/store requests from the datapath over a valid/ready handshake and sequences Memoria read/write strobes.
- Drives the tristate Data bus only during writes; returns aligned, extended load data with a one-cycle response pulse.
- Sits between the processor's MEM stage and Memoria; the instruction port (ReadPC/Instruction) is untouched.

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/mem_port_master_if.sv | 25 ++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/mem_port_master.sv | 164 ++++++++++++++++
 tb/tb_mem_port_master.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the Memoria data-port master: access sizes, FSM states,
// strobe patterns and byte-lane helpers.
package mem_pkg;

  localparam int BUS_W     = 32;
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = BUS_W / LANE_W;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MERGE,
    ST_WR,
    ST_RESP
  } state_t;

  // {Op2En, Op2RW}; both high is never produced
  localparam logic [1:0] STB_IDLE = 2'b00;
  localparam logic [1:0] STB_RD   = 2'b10;
  localparam logic [1:0] STB_WR   = 2'b01;

  localparam logic [NUM_LANES-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [NUM_LANES-1:0] BE_LO_HALF = 4'b0011;
  localparam logic [NUM_LANES-1:0] BE_HI_HALF = 4'b1100;
  localparam logic [NUM_LANES-1:0] BE_ALL     = 4'b1111;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } req_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_port_master_if.sv
// Datapath-side request/response handshake of the Memoria data-port master.
interface mem_port_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian load extract/extend and store lane merge (combinational).
// Merge path exists only when MEM_PORT_RMW_EN is defined.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]       size,
  input  logic             sgn,
  input  logic [1:0]       off,
  input  logic [BUS_W-1:0] rword,
`ifdef MEM_PORT_RMW_EN
  input  logic [BUS_W-1:0] wdata,
  output logic [BUS_W-1:0] mword,
`endif
  output logic [BUS_W-1:0] ldata
);

  logic [4:0]       shamt;
  logic [BUS_W-1:0] sh;

  always_comb begin
    shamt = 5'd0;
    case (size)
      SZ_BYTE: shamt = {off, 3'b000};
      SZ_HALF: shamt = {off[1], 1'b0, 3'b000};
      default: shamt = 5'd0;
    endcase
  end

  assign sh = rword >> shamt;

  always_comb begin
    ldata = sh;
    case (size)
      SZ_BYTE: ldata = {{24{sgn & sh[7]}},  sh[7:0]};
      SZ_HALF: ldata = {{16{sgn & sh[15]}}, sh[15:0]};
      default: ldata = sh;
    endcase
  end

`ifdef MEM_PORT_RMW_EN
  logic [NUM_LANES-1:0] be;
  logic [BUS_W-1:0]     wrep;

  // replicate store data into every candidate lane, then pick by byte enable
  always_comb begin
    be   = BE_ALL;
    wrep = wdata;
    case (size)
      SZ_BYTE: begin be = BE_BYTE0 << off;                     wrep = {4{wdata[7:0]}};  end
      SZ_HALF: begin be = off[1] ? BE_HI_HALF : BE_LO_HALF;    wrep = {2{wdata[15:0]}}; end
      default: begin be = BE_ALL;                              wrep = wdata;            end
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign mword[i*LANE_W +: LANE_W] = be[i] ? wrep[i*LANE_W +: LANE_W]
                                             : rword[i*LANE_W +: LANE_W];
  end
`endif

endmodule

// File: rtl/mem_port_master.sv
// Memoria data-port initiator: sequences Op2En/Op2RW for datapath loads/stores.
// Define MEM_PORT_RMW_EN to enable read-modify-write sub-word stores.
module mem_port_master
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_master_if.slave  req_if,
  output logic              Op2En,
  output logic              Op2RW,
  output logic [ADDR_W-1:0] ReadWriteAddr,
  inout  wire  [31:0]       Data
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t           state;
  req_t             req_q;
  logic [CW-1:0]    cnt;
  logic [BUS_W-1:0] wr_q;
  logic [BUS_W-1:0] ldata;
  logic [BUS_W-1:0] rword;
  logic             ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_rdata_q;

  logic acc, bad, sub_st;

  assign acc    = req_if.req_valid & ready_q;
  assign bad    = (req_if.req_size == SZ_ILL) | misaligned(req_if.req_size, req_if.req_addr[1:0]);
  assign sub_st = req_if.req_we & (req_if.req_size != SZ_WORD);

  assign req_if.req_ready = ready_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_err   = rsp_err_q;
  assign req_if.rsp_rdata = rsp_rdata_q;

  assign Data = Op2RW ? wr_q : 'z;

`ifdef MEM_PORT_RMW_EN
  logic [BUS_W-1:0] rd_q;
  logic [BUS_W-1:0] mword;
  // during MERGE the bus is idle, so the lane logic works from the captured word
  assign rword = (state == ST_MERGE) ? rd_q : Data;
`else
  assign rword = Data;
`endif

  mem_lane_align u_align (
    .size  (req_q.size),
    .sgn   (req_q.sgn),
    .off   (req_q.off),
    .rword (rword),
`ifdef MEM_PORT_RMW_EN
    .wdata (wr_q),
    .mword (mword),
`endif
    .ldata (ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      req_q          <= '0;
      cnt            <= '0;
      wr_q           <= '0;
      ready_q        <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      {Op2En, Op2RW} <= STB_IDLE;
      ReadWriteAddr  <= '0;
`ifdef MEM_PORT_RMW_EN
      rd_q           <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc) begin
            ready_q       <= 1'b0;
            req_q         <= '{we: req_if.req_we, size: req_if.req_size,
                               sgn: req_if.req_signed, off: req_if.req_addr[1:0]};
            ReadWriteAddr <= {2'b00, req_if.req_addr[ADDR_W-1:2]};
            wr_q          <= req_if.req_wdata;
`ifdef MEM_PORT_RMW_EN
            if (bad) begin
`else
            if (bad || sub_st) begin
`endif
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (req_if.req_we && !sub_st) begin
              state          <= ST_WR;
              {Op2En, Op2RW} <= STB_WR;
            end else begin
              state          <= ST_RD;
              {Op2En, Op2RW} <= STB_RD;
              cnt            <= CW'(RD_LAT - 1);
            end
          end else begin
            ready_q <= 1'b1;
          end
        end

        ST_RD: begin
          if (cnt == '0) begin
            {Op2En, Op2RW} <= STB_IDLE;
`ifdef MEM_PORT_RMW_EN
            if (req_q.we) begin
              rd_q  <= Data;
              state <= ST_MERGE;
            end else
`endif
            begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= req_q.we ? '0 : ldata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

`ifdef MEM_PORT_RMW_EN
        ST_MERGE: begin
          wr_q           <= mword;
          {Op2En, Op2RW} <= STB_WR;
          state          <= ST_WR;
        end
`endif

        ST_WR: begin
          {Op2En, Op2RW} <= STB_IDLE;
          state          <= ST_RESP;
          rsp_valid_q    <= 1'b1;
          rsp_err_q      <= 1'b0;
          rsp_rdata_q    <= '0;
        end

        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          ready_q     <= 1'b1;
          state       <= ST_IDLE;
        end

        default: begin
          {Op2En, Op2RW} <= STB_IDLE;
          ready_q        <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Scoreboard bench for mem_port_master with a small Memoria model on the Data bus.
module tb_mem_port_master;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Op2En, Op2RW;
  logic [31:0] ReadWriteAddr;
  wire  [31:0] Data;

  mem_port_master_if #(.ADDR_W(32)) bus();

  mem_port_master #(.RD_LAT(RD_LAT), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_if        (bus),
    .Op2En         (Op2En),
    .Op2RW         (Op2RW),
    .ReadWriteAddr (ReadWriteAddr),
    .Data          (Data)
  );

  always #5 clk = ~clk;

  // Memoria model: 16 words, combinational read, write on the strobe edge
  logic [31:0] mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign Data = (Op2En && !Op2RW) ? mem[ReadWriteAddr[3:0]] : 'z;

  always @(posedge clk) begin
    if (pre_en)     mem[pre_addr] <= pre_data;
    else if (Op2RW) mem[ReadWriteAddr[3:0]] <= Data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n_en;
    int          n_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s #%0d: got %h want %h", nm, id, act, exp);
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] rdata, input logic err,
                              input int lat, input int n_en, input int n_wr,
                              input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.id = id; e.rdata = rdata; e.err = err; e.lat = lat; e.n_en = n_en;
    e.n_wr = n_wr; e.addr = addr; e.wdata = wdata; e.acc = 0;
    return e;
  endfunction

  // monitor: strobe bookkeeping and scoreboard pops on every response pulse
  int          m_en = 0, m_wr = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        both_seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_en = 0; m_wr = 0;
    end else begin
      if (Op2En) begin m_en++; m_addr = ReadWriteAddr; end
      if (Op2RW) begin m_wr++; m_addr = ReadWriteAddr; m_wdata = Data; end
      if (Op2En && Op2RW) both_seen = 1'b1;
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", -1, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rdata", e.id, bus.rsp_rdata, e.rdata);
          chk("err",   e.id, bus.rsp_err, e.err);
          chk("lat",   e.id, cyc - e.acc + 1, e.lat);
          chk("n_en",  e.id, m_en, e.n_en);
          chk("n_wr",  e.id, m_wr, e.n_wr);
          if (e.n_en + e.n_wr > 0) chk("addr", e.id, m_addr, e.addr);
          if (e.n_wr > 0)          chk("wdata", e.id, m_wdata, e.wdata);
        end
        m_en = 0; m_wr = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input exp_t e);
    int n;
    @(negedge clk);
    bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      chk("accept_timeout", e.id, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  localparam int LD = RD_LAT + 1;

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 0, bus.req_ready, 0);
    chk("rst_op2en", 0, Op2En, 0);
    chk("rst_op2rw", 0, Op2RW, 0);
    chk("rst_rspv",  0, bus.rsp_valid, 0);
    chk("rst_rdata", 0, bus.rsp_rdata, 0);
    chk("rst_addr",  0, ReadWriteAddr, 0);
    preload(4'd0,  32'h8899AABB);
    preload(4'd15, 32'hCAFEF00D);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 0, bus.req_ready, 1);

    issue(0, 2'b00, 1, 32'h3, 0, mk(1,  32'hFFFFFF88, 0, LD, RD_LAT, 0, 0, 0));
    issue(0, 2'b01, 0, 32'h2, 0, mk(2,  32'h00008899, 0, LD, RD_LAT, 0, 0, 0));
    issue(0, 2'b01, 1, 32'h2, 0, mk(3,  32'hFFFF8899, 0, LD, RD_LAT, 0, 0, 0));
    issue(0, 2'b00, 0, 32'h1, 0, mk(4,  32'h000000AA, 0, LD, RD_LAT, 0, 0, 0));
    issue(0, 2'b00, 1, 32'h0, 0, mk(5,  32'hFFFFFFBB, 0, LD, RD_LAT, 0, 0, 0));
    issue(0, 2'b10, 1, 32'h0, 0, mk(6,  32'h8899AABB, 0, LD, RD_LAT, 0, 0, 0));
    issue(1, 2'b10, 0, 32'h8, 32'hDEADBEEF, mk(7, 0, 0, 2, 0, 1, 32'd2, 32'hDEADBEEF));
    issue(0, 2'b10, 0, 32'h8, 0, mk(8,  32'hDEADBEEF, 0, LD, RD_LAT, 0, 32'd2, 0));
    issue(1, 2'b10, 0, 32'h0, 32'h11223344, mk(9, 0, 0, 2, 0, 1, 32'd0, 32'h11223344));
`ifdef MEM_PORT_RMW_EN
    issue(1, 2'b00, 0, 32'h1, 32'hFFFFFF55, mk(10, 0, 0, RD_LAT+3, RD_LAT, 1, 0, 32'h11225544));
    issue(1, 2'b01, 0, 32'h2, 32'h1234BEEF, mk(11, 0, 0, RD_LAT+3, RD_LAT, 1, 0, 32'hBEEF5544));
    issue(0, 2'b10, 0, 32'h0, 0, mk(12, 32'hBEEF5544, 0, LD, RD_LAT, 0, 0, 0));
`else
    issue(1, 2'b00, 0, 32'h1, 32'hFFFFFF55, mk(10, 0, 1, 1, 0, 0, 0, 0));
    issue(1, 2'b01, 0, 32'h2, 32'h1234BEEF, mk(11, 0, 1, 1, 0, 0, 0, 0));
    issue(0, 2'b10, 0, 32'h0, 0, mk(12, 32'h11223344, 0, LD, RD_LAT, 0, 0, 0));
`endif
    issue(0, 2'b01, 0, 32'h5, 0, mk(13, 0, 1, 1, 0, 0, 0, 0));
    issue(0, 2'b10, 0, 32'h2, 0, mk(14, 0, 1, 1, 0, 0, 0, 0));
    issue(0, 2'b11, 0, 32'h0, 0, mk(15, 0, 1, 1, 0, 0, 0, 0));
    issue(0, 2'b10, 0, 32'hFFFFFFFC, 0, mk(16, 32'hCAFEF00D, 0, LD, RD_LAT, 0, 32'h3FFFFFFF, 0));
    issue(1, 2'b01, 0, 32'h3, 32'h0000ABCD, mk(17, 0, 1, 1, 0, 0, 0, 0));

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", 0, sb.size(), 0);

    // reset in the middle of a read: transaction is dropped silently
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h8; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rd_active", 18, Op2En, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_op2en", 18, Op2En, 0);
    chk("rst_mid_op2rw", 18, Op2RW, 0);
    chk("rst_mid_ready", 18, bus.req_ready, 0);
    chk("rst_mid_rspv",  18, bus.rsp_valid, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_after", 18, bus.req_ready, 1);
    repeat (RD_LAT + 4) @(negedge clk);

    chk("strobe_excl", 0, both_seen, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
